imem_loader: RTL and testbench

//  Write-side counterpart of the instruction ROM: boot loader that fills instruction memory.
//  - Accepts a byte stream over a valid/ready handshake.
//  - Packs bytes little-endian into INST_WIDTH words and issues one write per word.
//  - Holds the CPU in reset while a program image is loaded.
//  - Sits between the host byte link (e.g. UART RX) and the memory write port.

---
 rtl/imem_loader.sv | 154 +++++++++++++++
 tb/tb_imem_loader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot loader: packs a little-endian byte stream into 32-bit words and writes
// them to instruction memory while holding the CPU in reset. Optional LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int MEM_SIZE = 1024
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_start,
  input  logic [$clog2(MEM_SIZE):0]   i_num_words,
  input  logic [7:0]                  i_byte,
  input  logic                        i_byte_valid,
  output logic                        o_byte_ready,
  output logic                        o_we,
  output logic [$clog2(MEM_SIZE)+1:0] o_waddr,
  output logic [31:0]                 o_wdata,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_error,
  output logic                        o_cpu_rst_n
);

  // state   | meaning
  // IDLE    | after reset, CPU held in reset, waiting for i_start
  // COLLECT | accepting the four bytes of the current word
  // WRITE   | one-cycle memory write of the assembled word
  // CHECK   | accepting the trailing checksum word (checksum build only)
  // DONE    | load finished or rejected, waiting for a restart

  localparam int AW = $clog2(MEM_SIZE);
  localparam int CW = AW + 1;
  localparam int WW = AW + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [WW-1:0]   addr;
  logic [1:0]      byte_idx;
  logic [31:0]     word;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]     sum;
`endif

  assign o_waddr = addr;
  assign o_wdata = word;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      count        <= '0;
      addr         <= '0;
      byte_idx     <= '0;
      word         <= '0;
      o_byte_ready <= 1'b0;
      o_we         <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_error      <= 1'b0;
      o_cpu_rst_n  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum          <= '0;
`endif
    end else begin
      o_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            o_done      <= 1'b0;
            o_error     <= 1'b0;
            o_cpu_rst_n <= 1'b0;
            if (i_num_words == '0) begin
              state       <= S_DONE;
              o_done      <= 1'b1;
              o_cpu_rst_n <= 1'b1;
            end else if (i_num_words > CW'(MEM_SIZE)) begin
              state   <= S_DONE;
              o_done  <= 1'b1;
              o_error <= 1'b1;
            end else begin
              state        <= S_COLLECT;
              count        <= i_num_words;
              addr         <= '0;
              byte_idx     <= '0;
              o_busy       <= 1'b1;
              o_byte_ready <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
              sum          <= '0;
`endif
            end
          end
        end
        S_COLLECT: begin
          if (i_byte_valid) begin
            word[{byte_idx, 3'b000} +: 8] <= i_byte;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              state        <= S_WRITE;
              o_byte_ready <= 1'b0;
              o_we         <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          count <= count - CW'(1);
`ifdef LOADER_CHECKSUM_EN
          sum   <= sum + word;
`endif
          if (count == CW'(1)) begin
`ifdef LOADER_CHECKSUM_EN
            state        <= S_CHECK;
            o_byte_ready <= 1'b1;
`else
            state        <= S_DONE;
            o_busy       <= 1'b0;
            o_done       <= 1'b1;
            o_cpu_rst_n  <= 1'b1;
`endif
          end else begin
            // address only advances when another word follows, so it never wraps
            addr         <= addr + WW'(4);
            state        <= S_COLLECT;
            o_byte_ready <= 1'b1;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (i_byte_valid) begin
            word[{byte_idx, 3'b000} +: 8] <= i_byte;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              state        <= S_DONE;
              o_byte_ready <= 1'b0;
              o_busy       <= 1'b0;
              o_done       <= 1'b1;
              if ({i_byte, word[23:0]} != sum) o_error <= 1'b1;
              else o_cpu_rst_n <= 1'b1;
            end
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven length rules, randomized loads
// against a byte-stream packing model, plus reset and latency sequences.
module tb_imem_loader;
  localparam int MEM_SIZE = 1024;
  localparam int AW = $clog2(MEM_SIZE);

  logic            clk = 1'b0;
  logic            i_rst_n = 1'b0;
  logic            i_start = 1'b0;
  logic [AW:0]     i_num_words = '0;
  logic [7:0]      i_byte = '0;
  logic            i_byte_valid = 1'b0;
  logic            o_byte_ready, o_we, o_busy, o_done, o_error, o_cpu_rst_n;
  logic [AW+1:0]   o_waddr;
  logic [31:0]     o_wdata;

  always #5 clk = ~clk;

  imem_loader #(.MEM_SIZE(MEM_SIZE)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_num_words(i_num_words),
    .i_byte(i_byte), .i_byte_valid(i_byte_valid), .o_byte_ready(o_byte_ready),
    .o_we(o_we), .o_waddr(o_waddr), .o_wdata(o_wdata), .o_busy(o_busy),
    .o_done(o_done), .o_error(o_error), .o_cpu_rst_n(o_cpu_rst_n)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  logic [7:0]    stim[$];
  logic [AW+1:0] obs_addr[$];
  logic [31:0]   obs_data[$];
  int            rdy_in_we = 0;

  always @(negedge clk) begin
    if (o_we === 1'b1) begin
      obs_addr.push_back(o_waddr);
      obs_data.push_back(o_wdata);
      if (o_byte_ready !== 1'b0) rdy_in_we++;
    end
  end

  task automatic start_pulse(input int n);
    @(negedge clk);
    i_start = 1'b1;
    i_num_words = n[AW:0];
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // mode 0: always valid, 1: valid every other cycle, 2: random valid plus stray i_start
  task automatic send_bytes(input int mode);
    int idx = 0;
    int cyc = 0;
    logic v, rdy;
    while (idx < stim.size() && cyc < stim.size() * 8 + 100) begin
      case (mode)
        0: v = 1'b1;
        1: v = cyc[0];
        default: v = 1'($urandom_range(0, 1));
      endcase
      i_byte_valid = v;
      i_byte = v ? stim[idx] : 8'($urandom);
      if (mode == 2) i_start = ($urandom_range(0, 7) == 0);
      rdy = o_byte_ready;
      @(posedge clk);
      if (v && rdy) idx++;
      cyc++;
      @(negedge clk);
    end
    i_byte_valid = 1'b0;
    i_start = 1'b0;
    check("bytes_accepted", 64'(idx), 64'(stim.size()));
  endtask

  task automatic run_load(input int n, input int mode, input int bad_sum, input bit preset);
    logic [31:0] exp_w;
    logic [31:0] s;
    int t;
    if (!preset) begin
      stim.delete();
      for (int i = 0; i < 4 * n; i++) stim.push_back(8'($urandom));
    end
    s = '0;
    for (int i = 0; i < n; i++)
      s += {stim[4*i+3], stim[4*i+2], stim[4*i+1], stim[4*i]};
`ifdef LOADER_CHECKSUM_EN
    s += 32'(bad_sum);
    for (int k = 0; k < 4; k++) stim.push_back(s[8*k +: 8]);
`endif
    obs_addr.delete();
    obs_data.delete();
    rdy_in_we = 0;
    start_pulse(n);
    check("busy_after_start", o_busy, 1);
    check("done_cleared_on_start", {o_done, o_error}, 0);
    send_bytes(mode);
    t = 0;
    while (o_done !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", o_done, 1);
    @(negedge clk);
    check("write_count", 64'(obs_addr.size()), 64'(n));
    for (int i = 0; i < n && i < obs_addr.size(); i++) begin
      exp_w = {stim[4*i+3], stim[4*i+2], stim[4*i+1], stim[4*i]};
      check("waddr", obs_addr[i], 64'(4 * i));
      check("wdata", obs_data[i], exp_w);
    end
    check("error_flag", o_error, (bad_sum != 0));
    check("cpu_rst_n", o_cpu_rst_n, (bad_sum == 0));
    check("busy_end", {o_busy, o_byte_ready}, 0);
    check("ready_during_write", 64'(rdy_in_we), 0);
  endtask

  typedef struct {
    int n;
    bit done;
    bit err;
    bit cpu;
  } len_vec_t;

  typedef struct {
    int n;
    int mode;
  } load_vec_t;

  len_vec_t  lvec[4];
  load_vec_t dvec[5];

  initial begin
    lvec[0] = '{0, 1'b1, 1'b0, 1'b1};
    lvec[1] = '{MEM_SIZE + 1, 1'b1, 1'b1, 1'b0};
    lvec[2] = '{2 * MEM_SIZE - 1, 1'b1, 1'b1, 1'b0};
    lvec[3] = '{0, 1'b1, 1'b0, 1'b1};
    dvec[0] = '{1, 0};
    dvec[1] = '{3, 1};
    dvec[2] = '{4, 2};
    dvec[3] = '{7, 2};
    dvec[4] = '{2, 1};

    repeat (3) @(negedge clk);
    check("reset_outputs",
          {o_we, o_busy, o_done, o_error, o_cpu_rst_n, o_byte_ready, o_waddr, o_wdata}, 0);
    i_rst_n = 1'b1;
    @(negedge clk);
    check("idle_outputs", {o_busy, o_done, o_error, o_cpu_rst_n, o_byte_ready}, 0);

    // known two-word image
    stim.delete();
    stim = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load(2, 0, 0, 1'b1);
    if (obs_data.size() >= 2) begin
      check("img_w0", {obs_addr[0], obs_data[0]}, {12'h000, 32'h00000013});
      check("img_w1", {obs_addr[1], obs_data[1]}, {12'h004, 32'h00100093});
    end else check("img_writes", 64'(obs_data.size()), 2);

`ifndef LOADER_CHECKSUM_EN
    // last byte at N -> o_we at N+1 -> o_done at N+2
    stim.delete();
    for (int i = 0; i < 4; i++) stim.push_back(8'($urandom));
    start_pulse(1);
    send_bytes(0);
    check("lat_we", {o_we, o_byte_ready, o_done}, 3'b100);
    @(negedge clk);
    check("lat_done", {o_we, o_done, o_cpu_rst_n}, 3'b011);
`endif

    // length rules
    for (int v = 0; v < 4; v++) begin
      obs_addr.delete();
      obs_data.delete();
      start_pulse(lvec[v].n);
      check("len_flags", {o_done, o_error, o_cpu_rst_n, o_busy},
            {lvec[v].done, lvec[v].err, lvec[v].cpu, 1'b0});
      repeat (3) @(negedge clk);
      check("len_no_write", 64'(obs_addr.size()), 0);
    end

    // randomized loads
    for (int v = 0; v < 5; v++) run_load(dvec[v].n, dvec[v].mode, 0, 1'b0);

    // full memory
    run_load(MEM_SIZE, 0, 0, 1'b0);
    if (obs_addr.size() > 0)
      check("full_last_addr", obs_addr[obs_addr.size()-1], 64'(4 * (MEM_SIZE - 1)));

    // reset in the middle of word 1
    stim.delete();
    for (int i = 0; i < 2; i++) stim.push_back(8'($urandom));
    obs_addr.delete();
    obs_data.delete();
    start_pulse(2);
    send_bytes(0);
    i_rst_n = 1'b0;
    @(negedge clk);
    check("midload_reset_outputs",
          {o_we, o_busy, o_done, o_error, o_cpu_rst_n, o_byte_ready, o_waddr, o_wdata}, 0);
    i_rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("midload_no_write", 64'(obs_addr.size()), 0);
    check("midload_idle", {o_busy, o_done, o_byte_ready}, 0);
    run_load(2, 2, 0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    stim.delete();
    stim = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load(2, 0, 0, 1'b1);
    stim.delete();
    stim = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load(2, 0, 1, 1'b1);
    run_load(5, 2, 0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
